// File: rtl/of_ex_stage.sv
// OF/EX pipeline register: operand capture with write-back bypass,
// forwarding overlay, stall hold with operand refresh, flush to bubble.
module of_ex_stage #(
  parameter logic [31:0] NOP_INSTR   = 32'h00000013,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  input  logic [4:0]             in_rs1_sel,
  input  logic [4:0]             in_rs2_sel,
  input  logic [4:0]             in_rd_sel,
  input  logic                   in_wb_enable,
  input  logic [31:0]            rf_rs1_data,
  input  logic [31:0]            rf_rs2_data,
  input  logic                   wb_enable,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  input  logic                   fwd_rs1_enable,
  input  logic                   fwd_rs2_enable,
  input  logic [31:0]            fwd_rs1_data,
  input  logic [31:0]            fwd_rs2_data,
  input  logic                   stall_ofex,
  input  logic                   flush,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [4:0]             out_rd_sel,
  output logic                   out_wb_enable,
  output logic [31:0]            out_rs1_data,
  output logic [31:0]            out_rs2_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  rs1_q, rs2_q;
  logic [31:0] op1_q, op2_q;
  logic        held;
  logic        do_hold;
  logic        do_cap;
  logic        idle_stall;

  assign in_ready   = ~stall_ofex | flush;
  assign held       = state_q != S_EMPTY;
  assign do_cap     = ~flush & ~stall_ofex;
  assign do_hold    = ~flush & stall_ofex & held;
  assign idle_stall = ~flush & stall_ofex & ~held;

  function automatic logic [31:0] cap_op(
    input logic [4:0]  sel,
    input logic [31:0] rf,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (sel == 5'd0)
      return 32'd0;
    else if (we && wa == sel)
      return wd;
    else
      return rf;
  endfunction

  // In HOLD the held operand absorbs late results; fwd beats wb
  function automatic logic [31:0] refresh_op(
    input logic [4:0]  sel,
    input logic [31:0] cur,
    input logic        fe,
    input logic [31:0] fd,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (fe)
      return fd;
    else if (we && sel != 5'd0 && wa == sel)
      return wd;
    else
      return cur;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush:      state_d = S_EMPTY;
      do_hold:    state_d = S_HOLD;
      do_cap:     state_d = in_valid ? S_ISSUE : S_EMPTY;
      idle_stall: state_d = S_EMPTY;
      default:    state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_EMPTY;
      out_valid     <= 1'b0;
      out_pc        <= 32'd0;
      out_instr     <= NOP_INSTR;
      out_rd_sel    <= 5'd0;
      out_wb_enable <= 1'b0;
      rs1_q         <= 5'd0;
      rs2_q         <= 5'd0;
      op1_q         <= 32'd0;
      op2_q         <= 32'd0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        out_valid     <= 1'b0;
        out_instr     <= NOP_INSTR;
        out_rd_sel    <= 5'd0;
        out_wb_enable <= 1'b0;
      end else if (do_cap) begin
        out_valid     <= in_valid;
        out_pc        <= in_pc;
        out_instr     <= in_valid ? in_instr : NOP_INSTR;
        out_rd_sel    <= in_valid ? in_rd_sel : 5'd0;
        out_wb_enable <= in_valid & in_wb_enable;
        rs1_q         <= in_rs1_sel;
        rs2_q         <= in_rs2_sel;
        op1_q <= cap_op(in_rs1_sel, rf_rs1_data,
                        wb_enable, wb_addr, wb_data);
        op2_q <= cap_op(in_rs2_sel, rf_rs2_data,
                        wb_enable, wb_addr, wb_data);
      end else if (do_hold) begin
        op1_q <= refresh_op(rs1_q, op1_q,
                            fwd_rs1_enable, fwd_rs1_data,
                            wb_enable, wb_addr, wb_data);
        op2_q <= refresh_op(rs2_q, op2_q,
                            fwd_rs2_enable, fwd_rs2_data,
                            wb_enable, wb_addr, wb_data);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cycles <= '0;
    else if (state_d == S_HOLD && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

  assign out_rs1_data = (rs1_q == 5'd0) ? 32'd0 :
                        fwd_rs1_enable  ? fwd_rs1_data : op1_q;
  assign out_rs2_data = (rs2_q == 5'd0) ? 32'd0 :
                        fwd_rs2_enable  ? fwd_rs2_data : op2_q;

endmodule

// File: tb/tb_of_ex_stage.sv
// Directed bench for of_ex_stage: capture, bypass, forwarding,
// hold/refresh, flush, back-to-back issue, counter saturation, reset.
module tb_of_ex_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  in_rs1_sel, in_rs2_sel, in_rd_sel;
  logic        in_wb_enable;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fwd_rs1_enable, fwd_rs2_enable;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        stall_ofex, flush;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rd_sel;
  logic        out_wb_enable;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  of_ex_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_rs1_sel(in_rs1_sel), .in_rs2_sel(in_rs2_sel),
    .in_rd_sel(in_rd_sel), .in_wb_enable(in_wb_enable),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs2_enable(fwd_rs2_enable),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .stall_ofex(stall_ofex), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rd_sel(out_rd_sel), .out_wb_enable(out_wb_enable),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_instr = 0;
    in_rs1_sel = 0; in_rs2_sel = 0; in_rd_sel = 0;
    in_wb_enable = 0; rf_rs1_data = 0; rf_rs2_data = 0;
    wb_enable = 0; wb_addr = 0; wb_data = 0;
    fwd_rs1_enable = 0; fwd_rs2_enable = 0;
    fwd_rs1_data = 0; fwd_rs2_data = 0;
    stall_ofex = 0; flush = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1; in_pc = pc; in_instr = ins;
    in_rs1_sel = r1; in_rs2_sel = r2; in_rd_sel = rd;
    in_wb_enable = 1; rf_rs1_data = d1; rf_rs2_data = d2;
  endtask

  task automatic do_reset();
    resetn = 0;
    #3;
    resetn = 1;
    step();
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", out_valid); end
    total++; if (out_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", out_instr, NOP); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (out_rd_sel !== 5'd0 || out_wb_enable !== 1'b0) begin bad++; $display("FAIL rst_rd_wb got=%h/%h exp=0/0", out_rd_sel, out_wb_enable); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", stall_cycles); end
    total++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin bad++; $display("FAIL rst_ops got=%h/%h exp=0/0", out_rs1_data, out_rs2_data); end
    resetn = 1;
    step();
  endtask

  task automatic test_ready();
    idle();
    stall_ofex = 1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_stall got=%h exp=0", in_ready); end
    flush = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_flush got=%h exp=1", in_ready); end
    idle(); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_idle got=%h exp=1", in_ready); end
  endtask

  task automatic test_add();
    idle();
    drive(32'h100, 32'h002081B3, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    idle();
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%h exp=1", out_valid); end
    total++; if (out_rs1_data !== 32'd5) begin bad++; $display("FAIL add_rs1 got=%h exp=5", out_rs1_data); end
    total++; if (out_rs2_data !== 32'd7) begin bad++; $display("FAIL add_rs2 got=%h exp=7", out_rs2_data); end
    total++; if (out_rd_sel !== 5'd3 || out_wb_enable !== 1'b1) begin bad++; $display("FAIL add_rd got=%h/%h exp=3/1", out_rd_sel, out_wb_enable); end
    total++; if (out_pc !== 32'h100 || out_instr !== 32'h002081B3) begin bad++; $display("FAIL add_pcins got=%h/%h exp=100/002081b3", out_pc, out_instr); end
    step();
    total++; if (out_valid !== 1'b0 || out_instr !== NOP) begin bad++; $display("FAIL bubble got=%h/%h exp=0/%h", out_valid, out_instr, NOP); end
    total++; if (out_wb_enable !== 1'b0 || out_rd_sel !== 5'd0) begin bad++; $display("FAIL bubble_wb got=%h/%h exp=0/0", out_wb_enable, out_rd_sel); end
  endtask

  task automatic test_bypass();
    idle();
    drive(32'h104, 32'h0, 5'd4, 5'd5, 5'd9, 32'd1, 32'h22);
    wb_enable = 1; wb_addr = 5'd4; wb_data = 32'h99;
    step();
    idle(); #1;
    total++; if (out_rs1_data !== 32'h99) begin bad++; $display("FAIL wb_bypass got=%h exp=99", out_rs1_data); end
    total++; if (out_rs2_data !== 32'h22) begin bad++; $display("FAIL wb_nomatch got=%h exp=22", out_rs2_data); end
    drive(32'h108, 32'h0, 5'd0, 5'd7, 5'd9, 32'h55, 32'h10);
    fwd_rs1_enable = 1; fwd_rs1_data = 32'hAB;
    step();
    in_valid = 0;
    fwd_rs2_enable = 1; fwd_rs2_data = 32'h77; #1;
    total++; if (out_rs1_data !== 32'd0) begin bad++; $display("FAIL x0_fwd got=%h exp=0", out_rs1_data); end
    total++; if (out_rs2_data !== 32'h77) begin bad++; $display("FAIL fwd_rs2 got=%h exp=77", out_rs2_data); end
    stall_ofex = 1;
    fwd_rs1_enable = 0; fwd_rs2_enable = 0; #1;
    total++; if (out_rs2_data !== 32'h10) begin bad++; $display("FAIL fwd_off got=%h exp=10", out_rs2_data); end
    idle();
    step();
  endtask

  task automatic test_hold();
    idle();
    do_reset();
    drive(32'h200, 32'h00608433, 5'd1, 5'd6, 5'd8, 32'h11, 32'h60);
    step();
    // cycle 1: stall with a new candidate that must be ignored
    drive(32'h300, 32'h0, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2);
    stall_ofex = 1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%h exp=0", in_ready); end
    step();
    // cycle 2: fwd and wb both target rs2, fwd wins
    fwd_rs2_enable = 1; fwd_rs2_data = 32'h1234;
    wb_enable = 1; wb_addr = 5'd6; wb_data = 32'hDEAD; #1;
    total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL hold_c2 got=%h exp=1234", out_rs2_data); end
    step();
    // cycle 3: fwd gone, wb refreshes rs1
    fwd_rs2_enable = 0;
    wb_enable = 1; wb_addr = 5'd1; wb_data = 32'hBEEF; #1;
    total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL hold_c3 got=%h exp=1234", out_rs2_data); end
    total++; if (out_pc !== 32'h200 || out_rd_sel !== 5'd8 || out_valid !== 1'b1) begin bad++; $display("FAIL hold_stable got=%h/%h/%h exp=200/8/1", out_pc, out_rd_sel, out_valid); end
    step();
    // cycle 4: released
    idle(); #1;
    total++; if (out_rs2_data !== 32'h1234) begin bad++; $display("FAIL hold_c4 got=%h exp=1234", out_rs2_data); end
    total++; if (out_rs1_data !== 32'hBEEF) begin bad++; $display("FAIL hold_wb got=%h exp=beef", out_rs1_data); end
    total++; if (out_instr !== 32'h00608433 || out_wb_enable !== 1'b1) begin bad++; $display("FAIL hold_instr got=%h/%h exp=00608433/1", out_instr, out_wb_enable); end
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL hold_cnt got=%0d exp=3", stall_cycles); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_rel got=%h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    idle();
    drive(32'h400, 32'h00108093, 5'd1, 5'd0, 5'd1, 32'h3, 32'h0);
    step();
    drive(32'h404, 32'h00210113, 5'd2, 5'd0, 5'd2, 32'h4, 32'h0);
    stall_ofex = 1; flush = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%h exp=1", in_ready); end
    step();
    flush = 0;
    total++; if (out_valid !== 1'b0 || out_instr !== NOP) begin bad++; $display("FAIL flush_out got=%h/%h exp=0/%h", out_valid, out_instr, NOP); end
    total++; if (out_wb_enable !== 1'b0 || out_rd_sel !== 5'd0) begin bad++; $display("FAIL flush_wb got=%h/%h exp=0/0", out_wb_enable, out_rd_sel); end
    // stall while empty must neither count nor capture
    step(); step();
    total++; if (stall_cycles !== 16'd3 || out_valid !== 1'b0) begin bad++; $display("FAIL empty_stall got=%0d/%h exp=3/0", stall_cycles, out_valid); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    drive(32'h500, 32'h11111111, 5'd1, 5'd2, 5'd10, 32'hA1, 32'hA2);
    step();
    drive(32'h504, 32'h22222222, 5'd3, 5'd4, 5'd11, 32'hB1, 32'hB2);
    #1;
    total++; if (out_pc !== 32'h500 || out_rs1_data !== 32'hA1 || out_rd_sel !== 5'd10) begin bad++; $display("FAIL b2b_first got=%h/%h/%h exp=500/a1/a", out_pc, out_rs1_data, out_rd_sel); end
    step();
    idle(); #1;
    total++; if (out_pc !== 32'h504 || out_rs2_data !== 32'hB2 || out_rd_sel !== 5'd11) begin bad++; $display("FAIL b2b_second got=%h/%h/%h exp=504/b2/b", out_pc, out_rs2_data, out_rd_sel); end
    step();
  endtask

  task automatic test_saturate_reset();
    idle();
    do_reset();
    drive(32'h600, 32'h33333333, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    step();
    idle();
    stall_ofex = 1;
    repeat (65534) step();
    total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL cnt_fffe got=%h exp=fffe", stall_cycles); end
    step();
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL cnt_ffff got=%h exp=ffff", stall_cycles); end
    step(); step();
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ffff", stall_cycles); end
    #1 resetn = 0; #1;
    total++; if (out_valid !== 1'b0 || stall_cycles !== 16'd0) begin bad++; $display("FAIL async_rst got=%h/%h exp=0/0", out_valid, stall_cycles); end
    #1 resetn = 1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%h exp=0", in_ready); end
    stall_ofex = 0;
    drive(32'h700, 32'h44444444, 5'd5, 5'd6, 5'd7, 32'h5, 32'h6);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%h exp=1", in_ready); end
    step();
    idle(); #1;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h700) begin bad++; $display("FAIL post_rst_cap got=%h/%h exp=1/700", out_valid, out_pc); end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_add();
    test_bypass();
    test_hold();
    test_flush();
    test_back_to_back();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/of_ex_stage.md
OF_EX_STAGE -- requirements
Module: of_ex_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word driven when the stage holds a bubble.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, the width of the stall-cycle counter.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  decoded instruction present from OF.
REQ-005 in_pc, in_instr  in  32 each  PC and instruction word of the incoming instruction.
REQ-006 in_rs1_sel, in_rs2_sel, in_rd_sel  in  5 each  source and destination register indices.
REQ-007 in_wb_enable  in  1  incoming instruction writes rd.
REQ-008 rf_rs1_data, rf_rs2_data  in  32 each  register-file read data for in_rs1_sel/in_rs2_sel, same cycle.
REQ-009 wb_enable, wb_addr[4:0], wb_data[31:0]  in  1/5/32  register-file write port, same cycle.
REQ-010 fwd_rs1_enable, fwd_rs2_enable  in  1 each; fwd_rs1_data, fwd_rs2_data  in  32 each  registered forwarding results.
REQ-011 stall_ofex  in  1  hold the OF/EX register; flush  in  1  kill the held and incoming instruction.
REQ-012 in_ready  out  1  stage accepts in_* this cycle.
REQ-013 out_valid  out  1; out_pc, out_instr  out  32 each; out_rd_sel  out  5; out_wb_enable  out  1  issued instruction to EX.
REQ-014 out_rs1_data, out_rs2_data  out  32 each  final operands to EX.
REQ-015 stall_cycles  out  STALL_CNT_W  saturating count of cycles spent in HOLD.

Function
REQ-016 SHALL implement states EMPTY (no valid instr), ISSUE (valid instr, not stalled), HOLD (valid instr, stalled).
REQ-017 in_ready SHALL equal ~stall_ofex | flush, combinationally.
REQ-018 Capture: when in_ready and not flush, SHALL register in_* on the rising edge; out_valid next = in_valid; state next = in_valid ? ISSUE : EMPTY.
REQ-019 Capture of operand n: if in_rsn_sel==0 register 0; else if wb_enable and wb_addr==in_rsn_sel and wb_addr!=0 register wb_data; else register rf_rsn_data.
REQ-020 out_rsn_data SHALL be combinational: fwd_rsn_enable ? fwd_rsn_data : registered operand; forced to 0 when the registered rsn index is 0.
REQ-021 Latency: instruction presented in cycle N with in_ready SHALL appear on out_* in cycle N+1.
REQ-022 When stall_ofex=1 and flush=0 with a valid held instr, state SHALL be HOLD and out_pc/out_instr/out_rd_sel/out_wb_enable/out_valid SHALL not change.
REQ-023 In HOLD, each cycle fwd_rsn_enable=1 SHALL overwrite the registered operand n with fwd_rsn_data (refresh), so the value persists after forwarding deasserts.
REQ-024 In HOLD, wb_enable with wb_addr equal to a nonzero held rsn index SHALL also overwrite that operand; fwd refresh has priority over wb refresh.
REQ-025 stall_ofex with no valid held instr SHALL keep EMPTY and not count.
REQ-026 flush=1 SHALL override stall_ofex and capture: next out_valid=0, out_instr=NOP_INSTR, out_wb_enable=0, out_rd_sel=0, state EMPTY.
REQ-027 Bubble (in_valid=0 accepted) SHALL set out_instr=NOP_INSTR, out_wb_enable=0, out_rd_sel=0.
REQ-028 Transitions: EMPTY->ISSUE on valid capture; ISSUE->HOLD on stall_ofex; HOLD->ISSUE/EMPTY on stall release per REQ-018; any->EMPTY on flush.
REQ-029 stall_cycles SHALL increment by 1 for each cycle state is HOLD, saturating at all-ones.
REQ-030 out_wb_enable SHALL be 0 whenever out_valid=0.

Reset
REQ-031 On resetn=0, asynchronously: state EMPTY, out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_rd_sel=0, out_wb_enable=0, registered operands=0, stall_cycles=0.
REQ-032 Reset asserted mid-HOLD SHALL discard the held instruction; first cycle after release SHALL accept input (in_ready=~stall_ofex).

Verification
REQ-033 add x3,x1,x2 with rf data 5/7, no fwd -> next cycle out_valid=1, out_rs1_data=5, out_rs2_data=7, out_rd_sel=3.
REQ-034 Capture rs1=x4, rf_rs1_data=1, wb_enable=1 wb_addr=4 wb_data=0x99 -> out_rs1_data=0x99; rs1=x0 with fwd_rs1_enable=1 data 0xAB -> out_rs1_data=0.
REQ-035 Held instr rs2=x6, stall_ofex=1 for 3 cycles, fwd_rs2_enable=1 data 0x1234 in cycle 2 only -> out_rs2_data=0x1234 in cycles 2..4, out_* otherwise stable, stall_cycles=3.
REQ-036 flush=1 together with stall_ofex=1 and in_valid=1 -> next cycle out_valid=0, out_instr=32'h00000013, out_wb_enable=0, state EMPTY.
REQ-037 Force stall_cycles to 0xFFFE, hold 3 cycles -> reads 0xFFFF and stays; resetn pulse during HOLD -> out_valid=0, stall_cycles=0 immediately.
